ov7670_capture: RTL and testbench
=================================

// Module: ov7670_capture
// PURPOSE
//  Camera front end: samples OV7670 PCLK/HREF/VSYNC/D[7:0] (RGB565, 2 bytes/pixel) in the CLK domain,
//  packs each pixel to RGB332 and emits one write per pixel (W_ADDR/W_DATA/W_EN) into the dual-port M9K
//  frame buffer read by the VGA driver. Clips to WIDTH x HEIGHT; flags frame completion for the image processor.
// PARAMETERS
//  WIDTH   176  pixels per stored line; columns >= WIDTH are dropped
//  HEIGHT  144  stored lines per frame; lines >= HEIGHT are dropped
//  ADDR_W  15   W_ADDR width; WIDTH*HEIGHT <= 2**ADDR_W
// PORTS
//  CLK         in   1       system clock (50 MHz); only clock; PCLK treated as data, PCLK <= CLK/4
//  RESET       in   1       asynchronous, active-high reset
//  ENABLE      in   1       capture enable; sampled only at VSYNC rise
//  CAM_PCLK    in   1       camera pixel clock (async)
//  CAM_HREF    in   1       camera line valid (async)
//  CAM_VSYNC   in   1       camera frame sync, high = vertical blank (async)
//  CAM_D       in   8       camera data byte (async, valid at PCLK rise)
//  W_ADDR      out  ADDR_W  frame-buffer write address = row*WIDTH + col
//  W_DATA      out  8       RGB332 pixel
//  W_EN        out  1       one-CLK write strobe
//  FRAME_DONE  out  1       one-CLK pulse at VSYNC rise ending a frame with >= 1 stored line
//  BUSY        out  1       high while in a frame (VSYNC low, capture armed)
// BEHAVIOUR
//  Reset: W_ADDR=0, W_DATA=0, W_EN=0, FRAME_DONE=0, BUSY=0, state=WAIT_VS, col=row=line_base=0.
//  Sync: PCLK, HREF, VSYNC, D through the same 2-flop stage (aligned); pclk_rise = sync PCLK 0->1.
//  All HREF/VSYNC decisions are taken only on pclk_rise cycles.
//  States:
//   WAIT_VS: ignore data until VSYNC seen high; -> VBLANK. (first partial frame after reset is discarded)
//   VBLANK : VSYNC low at pclk_rise -> HBLANK if armed, else stay. Armed = ENABLE sampled at VSYNC rise.
//   HBLANK : HREF high -> capture byte0, -> BYTE1.
//   BYTE0  : HREF high -> capture byte0, -> BYTE1; HREF low -> end-of-line, -> HBLANK.
//   BYTE1  : HREF high -> capture byte1, emit pixel, -> BYTE0; HREF low -> end-of-line (odd byte dropped).
//   Any state except WAIT_VS: VSYNC high at pclk_rise -> VBLANK, col=row=line_base=0, W_ADDR=0.
//  Packing: byte0 -> W_DATA[7:5]=D[7:5], W_DATA[4:2]=D[2:0]; byte1 -> W_DATA[1:0]=D[4:3].
//  Emit: if col<WIDTH && row<HEIGHT: W_ADDR=line_base+col, W_DATA updated, W_EN=1 for one CLK; col
//   saturates at WIDTH. Out-of-range pixels: no write, W_ADDR/W_DATA hold.
//  End-of-line: only if col>0: row++ (saturate at HEIGHT), line_base+=WIDTH (only while row<HEIGHT), col=0.
//  Latency: exactly 4 CLK edges from PCLK rise at the pin flop to W_EN high (2 sync, 1 edge, 1 output reg).
//  FRAME_DONE: registered alongside the VSYNC-rise transition when row>0 and previous frame was armed.
//  BUSY=1 from VBLANK->HBLANK until VSYNC rise.
//  Simultaneous VSYNC high + HREF high: VSYNC wins, no write.
//  ENABLE low mid-frame: current frame completes; next frame not captured (stays VBLANK, no W_EN).
//  RESET mid-frame: all outputs to reset values next edge; resumes via WAIT_VS (no partial frame).
//  W_ADDR never exceeds WIDTH*HEIGHT-1; no W_EN during WAIT_VS or VBLANK.
// STRUCTURE
//  Package cam_pkg: RGB332 colour constants (RED, BLUE, WHITE...), default WIDTH/HEIGHT, state encoding.
//  Sub-module cam_sync: 2-flop synchronizer bank (PCLK, HREF, VSYNC, D) + PCLK rise detect.
//  Address: incremental line_base + col (no multiplier).
// TESTING
//  1 Reset, VSYNC 1->0, 2 lines x 176 px (byte0=0xE7, byte1=0x18) -> 352 W_EN, W_DATA=0xFF, addr 0..351.
//  2 Line of 200 px -> exactly 176 writes (addr 0..175), next line starts at 176.
//  3 150 lines then VSYNC rise -> last write addr 25343, FRAME_DONE one pulse, W_ADDR=0.
//  4 Line with 7 bytes -> 3 writes, odd byte dropped, next line base = 176.
//  5 ENABLE=0 before VSYNC rise -> following frame: 0 writes, BUSY=0, no FRAME_DONE.
//  6 RESET mid-line, then resume mid-frame -> no writes until VSYNC high->low; first write addr 0.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants and state encoding for the OV7670 capture front end.
package cam_pkg;

    localparam int CAM_WIDTH  = 176;
    localparam int CAM_HEIGHT = 144;
    localparam int CAM_ADDR_W = 15;

    localparam logic [7:0] RGB332_BLACK = 8'h00;
    localparam logic [7:0] RGB332_RED   = 8'hE0;
    localparam logic [7:0] RGB332_GREEN = 8'h1C;
    localparam logic [7:0] RGB332_BLUE  = 8'h03;
    localparam logic [7:0] RGB332_WHITE = 8'hFF;

    typedef enum logic [2:0] {
        ST_WAIT_VS = 3'd0,
        ST_VBLANK  = 3'd1,
        ST_HBLANK  = 3'd2,
        ST_BYTE0   = 3'd3,
        ST_BYTE1   = 3'd4
    } cam_state_e;

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer bank for the camera pins, followed by one aligned stage
// that also carries the registered PCLK rising-edge flag.
module cam_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pclk_i,
    input  logic       href_i,
    input  logic       vsync_i,
    input  logic [7:0] d_i,
    output logic       pclk_rise_o,
    output logic       href_o,
    output logic       vsync_o,
    output logic [7:0] d_o
);

    logic [10:0] meta_q;
    logic [10:0] sync_q;
    logic        pclk_prev_q;
    logic        rise_q;
    logic        href_q;
    logic        vsync_q;
    logic [7:0]  d_q;

    // All pins share the same flop chain so HREF/VSYNC/D stay aligned with PCLK.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q      <= '0;
            sync_q      <= '0;
            pclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            d_q         <= '0;
        end else begin
            meta_q      <= {pclk_i, href_i, vsync_i, d_i};
            sync_q      <= meta_q;
            pclk_prev_q <= sync_q[10];
            rise_q      <= sync_q[10] & ~pclk_prev_q;
            href_q      <= sync_q[9];
            vsync_q     <= sync_q[8];
            d_q         <= sync_q[7:0];
        end
    end

    assign pclk_rise_o = rise_q;
    assign href_o      = href_q;
    assign vsync_o     = vsync_q;
    assign d_o         = d_q;

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: packs each pixel to RGB332 and writes it into a
// WIDTH x HEIGHT frame buffer, pulsing FRAME_DONE when a stored frame ends.
module ov7670_capture
    import cam_pkg::*;
#(
    parameter int WIDTH  = CAM_WIDTH,
    parameter int HEIGHT = CAM_HEIGHT,
    parameter int ADDR_W = CAM_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              CAM_PCLK,
    input  logic              CAM_HREF,
    input  logic              CAM_VSYNC,
    input  logic [7:0]        CAM_D,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic              BUSY,
    output cam_state_e        DBG_STATE
);

    localparam int COL_W = $clog2(WIDTH + 1);
    localparam int ROW_W = $clog2(HEIGHT + 1);
    localparam logic [COL_W-1:0]  WIDTH_C  = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0]  HEIGHT_C = ROW_W'(HEIGHT);
    localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

    logic       pclk_rise;
    logic       href_s;
    logic       vsync_s;
    logic [7:0] d_s;

    cam_sync u_sync (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .pclk_i      (CAM_PCLK),
        .href_i      (CAM_HREF),
        .vsync_i     (CAM_VSYNC),
        .d_i         (CAM_D),
        .pclk_rise_o (pclk_rise),
        .href_o      (href_s),
        .vsync_o     (vsync_s),
        .d_o         (d_s)
    );

    cam_state_e        state_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [ADDR_W-1:0] line_base_q;
    logic [5:0]        byte0_q;
    logic              armed_q;
    logic              vs_prev_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [7:0]        w_data_q;
    logic              w_en_q;
    logic              frame_done_q;
    logic              busy_q;

    logic [ADDR_W-1:0] w_addr_d;
    logic              pix_in_range;
    logic              line_has_px;
    logic              row_in_range;

    assign w_addr_d     = line_base_q + ADDR_W'(col_q);
    assign row_in_range = (row_q < HEIGHT_C);
    assign pix_in_range = (col_q < WIDTH_C) && row_in_range;
    assign line_has_px  = (col_q != '0);

    // W_EN is a single-CLK strobe; W_ADDR/W_DATA are valid in that cycle and held otherwise.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_WAIT_VS;
            col_q        <= '0;
            row_q        <= '0;
            line_base_q  <= '0;
            byte0_q      <= '0;
            armed_q      <= 1'b0;
            vs_prev_q    <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            w_en_q       <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            w_en_q       <= 1'b0;
            frame_done_q <= 1'b0;
            if (pclk_rise) begin
                vs_prev_q <= vsync_s;
                if (state_q == ST_WAIT_VS) begin
                    if (vsync_s) begin
                        state_q <= ST_VBLANK;
                        armed_q <= ENABLE;
                    end
                end else if (vsync_s) begin
                    state_q     <= ST_VBLANK;
                    col_q       <= '0;
                    row_q       <= '0;
                    line_base_q <= '0;
                    w_addr_q    <= '0;
                    busy_q      <= 1'b0;
                    // Arm decision and frame completion are taken once, on the VSYNC edge.
                    if (!vs_prev_q) begin
                        armed_q      <= ENABLE;
                        frame_done_q <= armed_q && (row_q != '0);
                    end
                end else begin
                    case (state_q)
                        ST_VBLANK: begin
                            if (armed_q) begin
                                state_q <= ST_HBLANK;
                                busy_q  <= 1'b1;
                            end
                        end
                        ST_HBLANK, ST_BYTE0: begin
                            if (href_s) begin
                                byte0_q <= {d_s[7:5], d_s[2:0]};
                                state_q <= ST_BYTE1;
                            end else begin
                                state_q <= ST_HBLANK;
                                if (line_has_px) begin
                                    col_q <= '0;
                                    if (row_in_range) begin
                                        row_q       <= row_q + 1'b1;
                                        line_base_q <= line_base_q + WIDTH_A;
                                    end
                                end
                            end
                        end
                        ST_BYTE1: begin
                            if (href_s) begin
                                state_q <= ST_BYTE0;
                                if (pix_in_range) begin
                                    w_addr_q <= w_addr_d;
                                    w_data_q <= {byte0_q, d_s[4:3]};
                                    w_en_q   <= 1'b1;
                                    col_q    <= col_q + 1'b1;
                                end
                            end else begin
                                // Line ended on an odd byte: the half pixel is dropped.
                                state_q <= ST_HBLANK;
                                if (line_has_px) begin
                                    col_q <= '0;
                                    if (row_in_range) begin
                                        row_q       <= row_q + 1'b1;
                                        line_base_q <= line_base_q + WIDTH_A;
                                    end
                                end
                            end
                        end
                        default: state_q <= ST_WAIT_VS;
                    endcase
                end
            end
        end
    end

    assign W_ADDR     = w_addr_q;
    assign W_DATA     = w_data_q;
    assign W_EN       = w_en_q;
    assign FRAME_DONE = frame_done_q;
    assign BUSY       = busy_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture: byte-level camera driver, write scoreboard
// and a single summary line.
module tb_ov7670_capture;
    import cam_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cam_pclk;
    logic        cam_href;
    logic        cam_vsync;
    logic [7:0]  cam_d;
    logic [14:0] w_addr;
    logic [7:0]  w_data;
    logic        w_en;
    logic        frame_done;
    logic        busy;
    cam_state_e  dbg_state;

    int          vectors     = 0;
    int          miscompares = 0;
    int          done_pulses = 0;
    int          d0;
    logic [14:0] last_addr   = '0;
    logic [22:0] exp_q[$];

    always #5 clk = ~clk;

    ov7670_capture dut (
        .CLK        (clk),
        .RESET      (rst),
        .ENABLE     (enable),
        .CAM_PCLK   (cam_pclk),
        .CAM_HREF   (cam_href),
        .CAM_VSYNC  (cam_vsync),
        .CAM_D      (cam_d),
        .W_ADDR     (w_addr),
        .W_DATA     (w_data),
        .W_EN       (w_en),
        .FRAME_DONE (frame_done),
        .BUSY       (busy),
        .DBG_STATE  (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scoreboard: every W_EN strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (frame_done) done_pulses++;
        if (w_en) begin
            last_addr = w_addr;
            if (exp_q.size() == 0) begin
                chk("unexpected_w_en", 32'(w_en), 32'd0);
            end else begin
                logic [22:0] e;
                e = exp_q.pop_front();
                chk("w_addr", 32'(w_addr), 32'(e[22:8]));
                chk("w_data", 32'(w_data), 32'(e[7:0]));
            end
        end
    end

    task automatic pbyte(input logic href, input logic vs, input logic [7:0] d);
        @(negedge clk);
        cam_pclk  = 1'b0;
        cam_href  = href;
        cam_vsync = vs;
        cam_d     = d;
        @(negedge clk);
        @(negedge clk);
        cam_pclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic pixel(input logic [7:0] b0, input logic [7:0] b1, input logic exp_wr,
                         input int addr, input logic [7:0] dexp);
        if (exp_wr) exp_q.push_back({15'(addr), dexp});
        pbyte(1'b1, 1'b0, b0);
        pbyte(1'b1, 1'b0, b1);
    endtask

    task automatic hgap();
        pbyte(1'b0, 1'b0, 8'h00);
        pbyte(1'b0, 1'b0, 8'h00);
    endtask

    task automatic line(input int n_px, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] dexp, input int base, input int n_wr);
        for (int i = 0; i < n_px; i++) pixel(b0, b1, i < n_wr, base + i, dexp);
        hgap();
    endtask

    task automatic vs_high(input int n);
        for (int i = 0; i < n; i++) pbyte(1'b0, 1'b1, 8'h00);
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1;
        cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1; cam_d = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_w_addr", 32'(w_addr), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_WAIT_VS));
        rst = 1'b0;

        // Two full lines of white after the first VSYNC fall.
        vs_high(3);
        drain();
        chk("t1_state_vblank", 32'(dbg_state), 32'(ST_VBLANK));
        chk("t1_busy_vblank", 32'(busy), 32'd0);
        hgap();
        drain();
        chk("t1_busy_frame", 32'(busy), 32'd1);
        exp_q.push_back({15'd0, 8'hFF});
        pbyte(1'b1, 1'b0, 8'hE7);
        @(negedge clk);
        cam_pclk = 1'b0; cam_href = 1'b1; cam_d = 8'h18;
        @(negedge clk);
        @(negedge clk);
        cam_pclk = 1'b1;
        @(negedge clk); chk("lat_edge1", 32'(w_en), 32'd0);
        @(negedge clk); chk("lat_edge2", 32'(w_en), 32'd0);
        @(negedge clk); chk("lat_edge3", 32'(w_en), 32'd0);
        @(negedge clk); chk("lat_edge4", 32'(w_en), 32'd1);
        for (int i = 1; i < 176; i++) pixel(8'hE7, 8'h18, 1'b1, i, 8'hFF);
        hgap();
        line(176, 8'hE7, 8'h18, 8'hFF, 176, 176);
        drain();
        chk("t1_queue", 32'(exp_q.size()), 32'd0);
        chk("t1_last_addr", 32'(last_addr), 32'd351);

        // New frame: 200-pixel line is clipped to 176 writes.
        d0 = done_pulses;
        vs_high(2);
        drain();
        chk("t2_frame_done", 32'(done_pulses - d0), 32'd1);
        chk("t2_w_addr_zero", 32'(w_addr), 32'd0);
        chk("t2_busy_low", 32'(busy), 32'd0);
        hgap();
        line(200, 8'h24, 8'h08, 8'h31, 0, 176);
        drain();
        chk("t2_hold_addr", 32'(w_addr), 32'd175);
        chk("t2_hold_data", 32'(w_data), 32'h31);
        line(2, 8'hE7, 8'h18, 8'hFF, 176, 2);

        // Seven-byte line: three pixels, trailing byte dropped.
        for (int i = 0; i < 3; i++) pixel(8'hC3, 8'h10, 1'b1, 352 + i, 8'hCE);
        pbyte(1'b1, 1'b0, 8'hC3);
        hgap();
        line(1, 8'hE7, 8'h18, 8'hFF, 528, 1);
        drain();
        chk("t4_queue", 32'(exp_q.size()), 32'd0);
        chk("t4_last_addr", 32'(last_addr), 32'd528);

        // Fill to 150 lines; only rows below 144 are stored.
        for (int r = 4; r < 143; r++) line(1, 8'hE7, 8'h18, 8'hFF, r * 176, 1);
        line(176, 8'h5A, 8'h08, 8'h49, 25168, 176);
        for (int r = 144; r < 150; r++) line(1, 8'hE7, 8'h18, 8'hFF, 0, 0);
        drain();
        chk("t3_queue", 32'(exp_q.size()), 32'd0);
        chk("t3_last_addr", 32'(last_addr), 32'd25343);
        chk("t3_w_addr", 32'(w_addr), 32'd25343);
        d0 = done_pulses;
        vs_high(2);
        drain();
        chk("t3_frame_done", 32'(done_pulses - d0), 32'd1);
        chk("t3_w_addr_zero", 32'(w_addr), 32'd0);
        chk("t3_w_data_hold", 32'(w_data), 32'h49);
        chk("t3_busy_low", 32'(busy), 32'd0);

        // Disable before the VSYNC rise: following frame is ignored.
        hgap();
        line(1, 8'hE7, 8'h18, 8'hFF, 0, 1);
        drain();
        enable = 1'b0;
        d0 = done_pulses;
        vs_high(2);
        drain();
        chk("t5_done_last_armed", 32'(done_pulses - d0), 32'd1);
        hgap();
        line(3, 8'hE7, 8'h18, 8'hFF, 0, 0);
        drain();
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'(ST_VBLANK));
        d0 = done_pulses;
        vs_high(2);
        hgap();
        drain();
        chk("t5_no_done", 32'(done_pulses - d0), 32'd0);
        chk("t5_queue", 32'(exp_q.size()), 32'd0);

        // Reset mid-line, resume mid-frame, then restart on VSYNC.
        enable = 1'b1;
        vs_high(2);
        hgap();
        for (int i = 0; i < 3; i++) pixel(8'hE7, 8'h18, 1'b1, i, 8'hFF);
        drain();
        pbyte(1'b1, 1'b0, 8'hE7);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_w_addr", 32'(w_addr), 32'd0);
        chk("t6_rst_w_data", 32'(w_data), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_state", 32'(dbg_state), 32'(ST_WAIT_VS));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) pixel(8'hE7, 8'h18, 1'b0, 0, 8'h00);
        hgap();
        line(4, 8'hE7, 8'h18, 8'hFF, 0, 0);
        drain();
        chk("t6_no_writes", 32'(exp_q.size()), 32'd0);
        chk("t6_busy_resume", 32'(busy), 32'd0);
        vs_high(2);
        hgap();
        line(2, 8'h24, 8'h08, 8'h31, 0, 2);
        drain();
        chk("t6_queue", 32'(exp_q.size()), 32'd0);
        chk("t6_last_addr", 32'(last_addr), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
